// File: rtl/regfile_onehot_bank.sv
// Register bank written through a one-hot enable vector.
// Two combinational read ports with optional same-cycle write bypass.
module regfile_onehot_bank #(
  parameter int unsigned WIDTH    = 64,
  parameter int unsigned NREG     = 32,
  parameter int unsigned ZERO_REG = 31,
  parameter bit          BYPASS   = 1'b1,
  localparam int unsigned AW      = $clog2(NREG)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [NREG-1:0]  wr_onehot,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr_a,
  input  logic [AW-1:0]    rd_addr_b,
  output logic [WIDTH-1:0] rd_data_a,
  output logic [WIDTH-1:0] rd_data_b,
  output logic             onehot_err,
  output logic [15:0]      wr_count
);

  localparam logic [AW-1:0] ZIDX = AW'(ZERO_REG);

  logic [WIDTH-1:0] regs_q [NREG];
  logic [WIDTH-1:0] regs_d [NREG];
  logic             err_q;
  logic             err_d;
  logic [15:0]      cnt_q;
  logic [15:0]      cnt_d;

  logic any_set;
  logic multi_set;
  logic wr_valid;

  // Clearing the lowest set bit leaves something only if 2+ bits were set.
  assign any_set   = |wr_onehot;
  assign multi_set = |(wr_onehot & (wr_onehot - NREG'(1)));
  assign wr_valid  = any_set && !multi_set;

  always_comb begin
    for (int i = 0; i < NREG; i++) begin
      regs_d[i] = regs_q[i];
      if (wr_valid && wr_onehot[i] && (i != ZERO_REG))
        regs_d[i] = wr_data;
    end
  end

  always_comb begin
    err_d = err_q | multi_set;
    cnt_d = cnt_q;
    if (wr_valid && (cnt_q != 16'hFFFF))
      cnt_d = cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NREG; i++)
        regs_q[i] <= '0;
      err_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      for (int i = 0; i < NREG; i++)
        regs_q[i] <= regs_d[i];
      err_q <= err_d;
      cnt_q <= cnt_d;
    end
  end

  logic byp_a;
  logic byp_b;

  assign byp_a = BYPASS && wr_valid && wr_onehot[rd_addr_a];
  assign byp_b = BYPASS && wr_valid && wr_onehot[rd_addr_b];

  always_comb begin
    rd_data_a = regs_q[rd_addr_a];
    if (byp_a)
      rd_data_a = wr_data;
    if (rd_addr_a == ZIDX)
      rd_data_a = '0;
  end

  always_comb begin
    rd_data_b = regs_q[rd_addr_b];
    if (byp_b)
      rd_data_b = wr_data;
    if (rd_addr_b == ZIDX)
      rd_data_b = '0;
  end

  assign onehot_err = err_q;
  assign wr_count   = cnt_q;

endmodule

// File: tb/tb_regfile_onehot_bank.sv
// Directed bench for regfile_onehot_bank.
// u1 has bypass enabled, u0 has it disabled; both share inputs.
module tb_regfile_onehot_bank;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] wr_onehot;
  logic [63:0] wr_data;
  logic [4:0]  rd_addr_a;
  logic [4:0]  rd_addr_b;
  logic [63:0] rda1, rdb1, rda0, rdb0;
  logic        err1, err0;
  logic [15:0] cnt1, cnt0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  regfile_onehot_bank #(.BYPASS(1'b1)) u1 (
    .clk(clk), .reset_n(reset_n), .wr_onehot(wr_onehot),
    .wr_data(wr_data), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_data_a(rda1), .rd_data_b(rdb1),
    .onehot_err(err1), .wr_count(cnt1)
  );

  regfile_onehot_bank #(.BYPASS(1'b0)) u0 (
    .clk(clk), .reset_n(reset_n), .wr_onehot(wr_onehot),
    .wr_data(wr_data), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_data_a(rda0), .rd_data_b(rdb0),
    .onehot_err(err0), .wr_count(cnt0)
  );

  task automatic wr1(input int idx, input logic [63:0] d);
    @(negedge clk);
    wr_onehot = 32'h1 << idx;
    wr_data = d;
    @(posedge clk);
    #1 wr_onehot = '0;
  endtask

  task automatic test_reset;
    wr1(9, 64'h123);
    @(posedge clk);
    #3 reset_n = 1'b0;
    for (int i = 0; i < 32; i++) begin
      rd_addr_a = 5'(i);
      rd_addr_b = 5'(31 - i);
      #1;
      checks++;
      if (rda1 !== 64'h0 || rdb1 !== 64'h0 || rda0 !== 64'h0) begin
        errors++;
        $display("FAIL reset_read[%0d] got %h/%h/%h want 0", i, rda1, rdb1, rda0);
      end
    end
    checks++;
    if (err1 !== 1'b0 || cnt1 !== 16'd0 || cnt0 !== 16'd0) begin
      errors++;
      $display("FAIL reset_state err=%b cnt=%h/%h want 0", err1, cnt1, cnt0);
    end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_single_write;
    @(negedge clk);
    wr_onehot = 32'h0000_0020;
    wr_data = 64'hDEAD_BEEF_0123_4567;
    rd_addr_a = 5'd5;
    #1;
    checks++;
    if (rda1 !== 64'hDEAD_BEEF_0123_4567) begin
      errors++;
      $display("FAIL bypass_pre got %h want %h", rda1, 64'hDEAD_BEEF_0123_4567);
    end
    checks++;
    if (rda0 !== 64'h0) begin
      errors++;
      $display("FAIL nobypass_pre got %h want 0", rda0);
    end
    @(posedge clk);
    #1 wr_onehot = '0;
    #1;
    checks++;
    if (rda1 !== 64'hDEAD_BEEF_0123_4567 || rda0 !== 64'hDEAD_BEEF_0123_4567) begin
      errors++;
      $display("FAIL write_post got %h/%h want %h", rda1, rda0, 64'hDEAD_BEEF_0123_4567);
    end
    checks++;
    if (cnt1 !== 16'd1) begin
      errors++;
      $display("FAIL count_one got %0d want 1", cnt1);
    end
  endtask

  task automatic test_zero_reg;
    @(negedge clk);
    wr_onehot = 32'h8000_0000;
    wr_data = '1;
    rd_addr_b = 5'd31;
    #1;
    checks++;
    if (rdb1 !== 64'h0 || rdb0 !== 64'h0) begin
      errors++;
      $display("FAIL zero_pre got %h/%h want 0", rdb1, rdb0);
    end
    @(posedge clk);
    #1 wr_onehot = '0;
    #1;
    checks++;
    if (rdb1 !== 64'h0 || rdb0 !== 64'h0) begin
      errors++;
      $display("FAIL zero_post got %h/%h want 0", rdb1, rdb0);
    end
    checks++;
    if (cnt1 !== 16'd2) begin
      errors++;
      $display("FAIL zero_count got %0d want 2", cnt1);
    end
  endtask

  task automatic test_malformed;
    wr1(3, 64'h11);
    wr1(4, 64'h22);
    @(negedge clk);
    wr_onehot = 32'h0000_0018;
    wr_data = 64'hFF;
    rd_addr_a = 5'd3;
    rd_addr_b = 5'd4;
    #1;
    checks++;
    if (rda1 !== 64'h11 || rdb1 !== 64'h22) begin
      errors++;
      $display("FAIL bad_no_bypass got %h/%h want 11/22", rda1, rdb1);
    end
    @(posedge clk);
    #1 wr_onehot = '0;
    #1;
    checks++;
    if (rda1 !== 64'h11 || rdb1 !== 64'h22 || rda0 !== 64'h11) begin
      errors++;
      $display("FAIL bad_suppress got %h/%h/%h want 11/22/11", rda1, rdb1, rda0);
    end
    checks++;
    if (err1 !== 1'b1 || err0 !== 1'b1) begin
      errors++;
      $display("FAIL bad_flag got %b/%b want 1", err1, err0);
    end
    checks++;
    if (cnt1 !== 16'd4) begin
      errors++;
      $display("FAIL bad_count got %0d want 4", cnt1);
    end
    wr1(6, 64'h66);
    #1;
    checks++;
    if (err1 !== 1'b1 || cnt1 !== 16'd5) begin
      errors++;
      $display("FAIL sticky err=%b cnt=%0d want 1/5", err1, cnt1);
    end
  endtask

  task automatic test_dual_read;
    wr1(2, 64'h77);
    wr1(7, 64'hA5);
    rd_addr_a = 5'd7;
    rd_addr_b = 5'd7;
    #1;
    checks++;
    if (rda1 !== 64'hA5 || rdb1 !== 64'hA5 || rdb0 !== 64'hA5) begin
      errors++;
      $display("FAIL dual_read got %h/%h/%h want a5", rda1, rdb1, rdb0);
    end
    rd_addr_a = 5'd2;
    wr1(7, 64'h5A);
    #1;
    checks++;
    if (rda1 !== 64'h77 || rdb1 !== 64'h5A) begin
      errors++;
      $display("FAIL isolate got %h/%h want 77/5a", rda1, rdb1);
    end
    checks++;
    if (cnt1 !== 16'd8) begin
      errors++;
      $display("FAIL dual_count got %0d want 8", cnt1);
    end
  endtask

  task automatic test_saturation;
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    checks++;
    if (err1 !== 1'b0 || cnt1 !== 16'd0) begin
      errors++;
      $display("FAIL err_clear err=%b cnt=%0d want 0/0", err1, cnt1);
    end
    reset_n = 1'b1;
    @(negedge clk);
    wr_onehot = 32'h1;
    wr_data = 64'h1;
    repeat (65540) @(posedge clk);
    #1 wr_onehot = '0;
    #1;
    checks++;
    if (cnt1 !== 16'hFFFF || cnt0 !== 16'hFFFF) begin
      errors++;
      $display("FAIL saturate got %h/%h want ffff", cnt1, cnt0);
    end
  endtask

  task automatic test_reset_mid_write;
    @(negedge clk);
    wr_onehot = 32'h2;
    wr_data = 64'hBB;
    rd_addr_a = 5'd1;
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (rda0 !== 64'h0 || cnt1 !== 16'd0) begin
      errors++;
      $display("FAIL mid_reset got %h cnt=%0d want 0/0", rda0, cnt1);
    end
    @(negedge clk);
    wr_data = 64'hCC;
    reset_n = 1'b1;
    @(posedge clk);
    #1 wr_onehot = '0;
    #1;
    checks++;
    if (rda0 !== 64'hCC || cnt1 !== 16'd1 || err1 !== 1'b0) begin
      errors++;
      $display("FAIL first_write got %h cnt=%0d err=%b want cc/1/0", rda0, cnt1, err1);
    end
  endtask

  initial begin
    reset_n = 1'b0;
    wr_onehot = '0;
    wr_data = '0;
    rd_addr_a = '0;
    rd_addr_b = '0;
    #12 reset_n = 1'b1;
    test_reset();
    test_single_write();
    test_zero_reg();
    test_malformed();
    test_dual_read();
    test_saturation();
    test_reset_mid_write();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
